fixed_point_multiplier_pipe: RTL and testbench



---
 rtl/fixed_point_pkg.sv | 30 +++
 rtl/fixed_point_round_sat.sv | 55 +++++
 rtl/fixed_point_multiplier_pipe.sv | 131 +++++++++++++
 tb/tb_fixed_point_multiplier_pipe.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Shared types and elaboration-time helpers for the fixed-point datapath blocks.
package fixed_point_pkg;

    typedef enum logic {
        ROUND_TRUNC   = 1'b0,
        ROUND_HALF_UP = 1'b1
    } round_mode_e;

    function automatic int max_int(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    function automatic int min_int(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    function automatic int diff_int(input int x, input int y);
        return x - y;
    endfunction

    // A full signed product needs the sum of both word widths and both fraction widths.
    function automatic int prod_width(input int a_word, input int b_word);
        return a_word + b_word;
    endfunction

    function automatic int prod_frac(input int a_frac, input int b_frac);
        return a_frac + b_frac;
    endfunction

endpackage

// File: rtl/fixed_point_round_sat.sv
// Combinational re-quantiser: aligns a signed fixed-point word to a new Q-format,
// optionally rounding half-up, then saturates or wraps into the output word.
module fixed_point_round_sat
    import fixed_point_pkg::*;
#(
    parameter int          IN_W       = 18,
    parameter int          IN_FRAC    = 16,
    parameter int          OUT_W      = 10,
    parameter int          OUT_FRAC   = 8,
    parameter round_mode_e ROUND_MODE = ROUND_HALF_UP,
    parameter bit          SATURATE   = 1'b1
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    ovf
);

    localparam int D       = diff_int(IN_FRAC, OUT_FRAC);
    localparam int SHL     = -min_int(D, 0);
    // One guard bit absorbs the rounding carry; left shifts widen by the shift amount.
    localparam int ALIGN_W = IN_W + 1 + SHL;
    localparam int CMP_W   = max_int(ALIGN_W, OUT_W + 1);

    localparam logic signed [CMP_W-1:0] C_MAX = {{(CMP_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [CMP_W-1:0] C_MIN = {{(CMP_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic signed [ALIGN_W-1:0] ext;
    logic signed [ALIGN_W-1:0] aligned;
    logic signed [CMP_W-1:0]   wide;

    assign ext = ALIGN_W'(din);

    if (D > 0) begin : g_shr
        localparam logic signed [ALIGN_W-1:0] HALF =
            (ROUND_MODE == ROUND_HALF_UP) ? (ALIGN_W'(1) << (D - 1)) : '0;
        assign aligned = (ext + HALF) >>> D;
    end else begin : g_shl
        assign aligned = ext <<< SHL;
    end

    assign wide = CMP_W'(aligned);

    always_comb begin
        dout = wide[OUT_W-1:0];
        ovf  = 1'b0;
        if (wide > C_MAX) begin
            ovf = 1'b1;
            if (SATURATE) dout = C_MAX[OUT_W-1:0];
        end else if (wide < C_MIN) begin
            ovf = 1'b1;
            if (SATURATE) dout = C_MIN[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/fixed_point_multiplier_pipe.sv
// Three-stage valid/ready signed fixed-point multiplier: operand register, full
// product register, then rounded/saturated result register with sticky overflow.
module fixed_point_multiplier_pipe
    import fixed_point_pkg::*;
#(
    parameter int A_FRAC_LEN = 8,
    parameter int A_WORD_LEN = 9,
    parameter int B_FRAC_LEN = 8,
    parameter int B_WORD_LEN = 9,
    parameter int C_FRAC_LEN = 8,
    parameter int C_WORD_LEN = 10,
    parameter int ROUND_MODE = 1,
    parameter int SATURATE   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [A_WORD_LEN-1:0] a,
    input  logic signed [B_WORD_LEN-1:0] b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [C_WORD_LEN-1:0] c,
    output logic                         ovf,
    output logic                         ovf_sticky,
    input  logic                         clr
);

    localparam int P_W    = prod_width(A_WORD_LEN, B_WORD_LEN);
    localparam int P_FRAC = prod_frac(A_FRAC_LEN, B_FRAC_LEN);

    logic                         s1_valid_q, s1_valid_d;
    logic signed [A_WORD_LEN-1:0] a_q, a_d;
    logic signed [B_WORD_LEN-1:0] b_q, b_d;
    logic                         s2_valid_q, s2_valid_d;
    logic signed [P_W-1:0]        prod_q, prod_d;
    logic                         s3_valid_q, s3_valid_d;
    logic signed [C_WORD_LEN-1:0] c_q, c_d;
    logic                         ovf_q, ovf_d;
    logic                         ovf_sticky_q, ovf_sticky_d;

    logic                         s1_load, s2_load, s3_load;
    logic signed [C_WORD_LEN-1:0] rs_c;
    logic                         rs_ovf;

    // A stage may load whenever it is empty or its contents move on this cycle.
    assign s3_load  = !s3_valid_q || out_ready;
    assign s2_load  = !s2_valid_q || s3_load;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    fixed_point_round_sat #(
        .IN_W       (P_W),
        .IN_FRAC    (P_FRAC),
        .OUT_W      (C_WORD_LEN),
        .OUT_FRAC   (C_FRAC_LEN),
        .ROUND_MODE ((ROUND_MODE != 0) ? ROUND_HALF_UP : ROUND_TRUNC),
        .SATURATE   (SATURATE != 0)
    ) u_round_sat (
        .din  (prod_q),
        .dout (rs_c),
        .ovf  (rs_ovf)
    );

    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latch).
        s1_valid_d   = s1_valid_q;
        a_d          = a_q;
        b_d          = b_q;
        s2_valid_d   = s2_valid_q;
        prod_d       = prod_q;
        s3_valid_d   = s3_valid_q;
        c_d          = c_q;
        ovf_d        = ovf_q;
        ovf_sticky_d = ovf_sticky_q;

        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                a_d = a;
                b_d = b;
            end
        end
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) prod_d = P_W'(a_q) * P_W'(b_q);
        end
        if (s3_load) begin
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                c_d   = rs_c;
                ovf_d = rs_ovf;
            end
        end

        // An overflow leaving the block in the same cycle as clr must still be recorded.
        if (clr) ovf_sticky_d = 1'b0;
        if (s3_valid_q && out_ready && ovf_q) ovf_sticky_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            s1_valid_q   <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            s2_valid_q   <= 1'b0;
            prod_q       <= '0;
            s3_valid_q   <= 1'b0;
            c_q          <= '0;
            ovf_q        <= 1'b0;
            ovf_sticky_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            a_q          <= a_d;
            b_q          <= b_d;
            s2_valid_q   <= s2_valid_d;
            prod_q       <= prod_d;
            s3_valid_q   <= s3_valid_d;
            c_q          <= c_d;
            ovf_q        <= ovf_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign out_valid  = s3_valid_q;
    assign c          = c_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_fixed_point_multiplier_pipe.sv
// Bench for fixed_point_multiplier_pipe: default instance plus three format variants,
// directed corner cases and a randomized valid/ready stream against a real-arithmetic model.
module tb_fixed_point_multiplier_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic clr = 1'b0;
    logic signed [8:0] a = '0;
    logic signed [8:0] b = '0;

    logic dut_in_ready, dut_out_valid, dut_ovf, dut_sticky;
    logic signed [9:0] dut_c;
    logic r0_in_ready, r0_out_valid, r0_ovf, r0_sticky;
    logic signed [9:0] r0_c;
    logic s1_in_ready, s1_out_valid, s1_ovf, s1_sticky;
    logic signed [8:0] s1_c;
    logic s0_in_ready, s0_out_valid, s0_ovf, s0_sticky;
    logic signed [8:0] s0_c;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fixed_point_multiplier_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(dut_in_ready), .a(a), .b(b),
        .out_valid(dut_out_valid), .out_ready(out_ready), .c(dut_c), .ovf(dut_ovf),
        .ovf_sticky(dut_sticky), .clr(clr)
    );

    fixed_point_multiplier_pipe #(.ROUND_MODE(0)) dut_r0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0_in_ready), .a(a), .b(b),
        .out_valid(r0_out_valid), .out_ready(1'b1), .c(r0_c), .ovf(r0_ovf),
        .ovf_sticky(r0_sticky), .clr(clr)
    );

    fixed_point_multiplier_pipe #(.C_WORD_LEN(9), .SATURATE(1)) dut_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s1_in_ready), .a(a), .b(b),
        .out_valid(s1_out_valid), .out_ready(1'b1), .c(s1_c), .ovf(s1_ovf),
        .ovf_sticky(s1_sticky), .clr(clr)
    );

    fixed_point_multiplier_pipe #(.C_WORD_LEN(9), .SATURATE(0)) dut_s0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s0_in_ready), .a(a), .b(b),
        .out_valid(s0_out_valid), .out_ready(1'b1), .c(s0_c), .ovf(s0_ovf),
        .ovf_sticky(s0_sticky), .clr(clr)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Q1.8 x Q1.8 -> real value scaled to output LSBs, rounded/truncated, then range-limited.
    function automatic void ref_model(input int av, input int bv, input bit rnd, input bit sat,
                                      input int cw, output longint cv, output bit ov);
        real    x;
        longint v, mx, mn, span;
        x    = real'(av * bv) / 256.0;
        v    = longint'($floor(x + (rnd ? 0.5 : 0.0)));
        span = longint'(1) << cw;
        mx   = span / 2 - 1;
        mn   = -(span / 2);
        ov   = (v > mx) || (v < mn);
        if (!ov) cv = v;
        else if (sat) cv = (v > mx) ? mx : mn;
        else begin
            cv = ((v % span) + span) % span;
            if (cv > mx) cv = cv - span;
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Sends one pair into an empty pipeline and returns at the sample point where outputs are valid.
    task automatic run_one(input int av, input int bv);
        int lat;
        cycle();
        in_valid  = 1'b1;
        a         = 9'(av);
        b         = 9'(bv);
        out_ready = 1'b1;
        @(negedge clk);
        check("accept", dut_in_ready, 1);
        lat = 0;
        do begin
            cycle();
            in_valid = 1'b0;
            lat++;
            @(negedge clk);
        end while (!dut_out_valid && lat < 10);
        check("latency", lat, 3);
    endtask

    initial begin
        longint exp_c;
        bit     exp_o;

        // ---------------- reset state ----------------
        repeat (2) cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", dut_in_ready, 1);
        check("rst_out_valid", dut_out_valid, 0);
        check("rst_c", dut_c, 0);
        check("rst_ovf", dut_ovf, 0);
        check("rst_sticky", dut_sticky, 0);
        check("rst_r0", {r0_in_ready, r0_out_valid, r0_ovf, r0_sticky}, 4'b1000);
        check("rst_r0_c", r0_c, 0);
        check("rst_s1", {s1_in_ready, s1_out_valid, s1_ovf, s1_sticky}, 4'b1000);
        check("rst_s1_c", s1_c, 0);
        check("rst_s0", {s0_in_ready, s0_out_valid, s0_ovf, s0_sticky}, 4'b1000);
        check("rst_s0_c", s0_c, 0);

        // ---------------- basic product ----------------
        run_one(128, 128);
        check("half_sq_c", dut_c, 64);
        check("half_sq_ovf", dut_ovf, 0);

        // ---------------- -1.0 x -1.0 across formats ----------------
        run_one(-256, -256);
        check("m1sq_c", dut_c, 256);
        check("m1sq_ovf", dut_ovf, 0);
        check("m1sq_sat_c", s1_c, 255);
        check("m1sq_sat_ovf", s1_ovf, 1);
        check("m1sq_wrap_c", s0_c, -256);
        check("m1sq_wrap_ovf", s0_ovf, 1);
        cycle();
        @(negedge clk);
        check("m1sq_sat_sticky", s1_sticky, 1);
        check("m1sq_wrap_sticky", s0_sticky, 1);
        check("m1sq_dut_sticky", dut_sticky, 0);

        // ---------------- rounding ----------------
        run_one(1, 128);
        check("rnd_pos_half_up", dut_c, 1);
        check("rnd_pos_trunc", r0_c, 0);
        run_one(-1, 128);
        check("rnd_neg_half_up", dut_c, 0);
        check("rnd_neg_trunc", r0_c, -1);
        cycle();

        // ---------------- backpressure: a=-k, b=-1.0 -> c=k ----------------
        begin
            int k = 1;
            int stall_cnt = 0;
            int held_c = 0;
            int got_q[$];
            for (int cyc = 0; cyc < 80 && got_q.size() < 6; cyc++) begin
                cycle();
                in_valid  = (k <= 6);
                a         = 9'(-k);
                b         = -9'sd256;
                out_ready = !(got_q.size() >= 1 && stall_cnt < 8);
                @(negedge clk);
                if (in_valid && dut_in_ready) k++;
                if (dut_out_valid && !out_ready) begin
                    if (stall_cnt == 0) held_c = int'(dut_c);
                    else check("bp_hold_c", dut_c, held_c);
                    stall_cnt++;
                    if (stall_cnt == 8) check("bp_in_ready_full", dut_in_ready, 0);
                end
                if (dut_out_valid && out_ready) got_q.push_back(int'(dut_c));
            end
            check("bp_count", got_q.size(), 6);
            foreach (got_q[i]) check("bp_order", got_q[i], i + 1);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end

        // ---------------- randomized valid/ready stream ----------------
        begin
            int     sent = 0;
            int     rcvd = 0;
            int     av, bv;
            longint exp_cq[$];
            bit     exp_oq[$];
            bit     prev_stall = 1'b0;
            int     prev_c = 0;
            bit     prev_ovf = 1'b0;
            repeat (4) cycle();
            for (int cyc = 0; cyc < 20000 && rcvd < 1000; cyc++) begin
                cycle();
                in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                av        = int'($urandom_range(0, 511)) - 256;
                bv        = int'($urandom_range(0, 511)) - 256;
                a         = 9'(av);
                b         = 9'(bv);
                @(negedge clk);
                if (prev_stall) begin
                    check("rand_hold_valid", dut_out_valid, 1);
                    check("rand_hold_c", dut_c, prev_c);
                    check("rand_hold_ovf", dut_ovf, prev_ovf);
                end
                if (in_valid && dut_in_ready) begin
                    ref_model(av, bv, 1'b1, 1'b1, 10, exp_c, exp_o);
                    exp_cq.push_back(exp_c);
                    exp_oq.push_back(exp_o);
                    sent++;
                end
                if (dut_out_valid && out_ready) begin
                    if (exp_cq.size() == 0) check("rand_unexpected_out", 1, 0);
                    else begin
                        check("rand_c", dut_c, exp_cq.pop_front());
                        check("rand_ovf", dut_ovf, exp_oq.pop_front());
                    end
                    rcvd++;
                end
                prev_stall = dut_out_valid && !out_ready;
                prev_c     = int'(dut_c);
                prev_ovf   = dut_ovf;
            end
            check("rand_count", rcvd, 1000);
            check("rand_pending", exp_cq.size(), 0);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            repeat (5) cycle();
        end

        // ---------------- reset with three samples in flight ----------------
        begin
            int stray = 0;
            @(negedge clk);
            check("pre_rst_sticky", s1_sticky, 1);
            cycle();
            out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                in_valid = 1'b1;
                a        = 9'(5 + i);
                b        = 9'sd100;
                @(negedge clk);
                check("flight_accept", dut_in_ready, 1);
                cycle();
            end
            in_valid = 1'b0;
            @(negedge clk);
            check("pre_rst_out_valid", dut_out_valid, 1);
            cycle();
            rst = 1'b1;
            cycle();
            rst       = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            check("post_rst_out_valid", dut_out_valid, 0);
            check("post_rst_sticky", s1_sticky, 0);
            check("post_rst_in_ready", dut_in_ready, 1);
            for (int i = 0; i < 10; i++) begin
                cycle();
                @(negedge clk);
                if (dut_out_valid) stray++;
            end
            check("post_rst_stray", stray, 0);
        end

        // ---------------- clr without overflow clears sticky ----------------
        run_one(-256, -256);
        cycle();
        @(negedge clk);
        check("clr_pre_sticky", s1_sticky, 1);
        cycle();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        @(negedge clk);
        check("clr_post_sticky", s1_sticky, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
